// File: rtl/cpu_bus_arbiter.sv
// rtl/cpu_bus_arbiter.sv - round-robin CPU bus arbiter with hold timeout (optional ARB_PRIORITY_EN: requester 0 priority)
module cpu_bus_arbiter #(
    parameter int N_REQ    = 4,
    parameter int MAX_HOLD = 8,
    parameter int ID_W     = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] lock,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  gnt_id,
    output logic             busy,
    output logic             timeout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } state_t;

    localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD - 1);

    state_t          state;
    logic [ID_W-1:0] ptr;
    logic [7:0]      hold_cnt;

    logic [ID_W-1:0] win_id;
    logic            win_valid;
    logic [ID_W-1:0] next_ptr;
    logic [ID_W-1:0] rel_ptr;
    int              idx;

    // rotating search from ptr upward; first requesting index wins
    always_comb begin
        win_valid = 1'b0;
        win_id    = '0;
        idx       = 0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = (int'(ptr) + i) % N_REQ;
            if (!win_valid && req[idx]) begin
                win_valid = 1'b1;
                win_id    = ID_W'(idx);
            end
        end
`ifdef ARB_PRIORITY_EN
        if (req[0]) begin
            win_valid = 1'b1;
            win_id    = '0;
        end
`endif
    end

    // pointer value to use after the current owner lets go
    always_comb begin
        next_ptr = (gnt_id == ID_W'(N_REQ - 1)) ? '0 : gnt_id + ID_W'(1);
`ifdef ARB_PRIORITY_EN
        // requester 0 jumps the queue, so it must not disturb the rotation among the others
        rel_ptr = (gnt_id == '0) ? ptr : next_ptr;
`else
        rel_ptr = next_ptr;
`endif
    end

    // arbitration FSM with registered grant, busy and timeout outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            gnt      <= '0;
            gnt_id   <= '0;
            busy     <= 1'b0;
            timeout  <= 1'b0;
            ptr      <= '0;
            hold_cnt <= '0;
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (win_valid) begin
                        gnt      <= {{(N_REQ-1){1'b0}}, 1'b1} << win_id;
                        gnt_id   <= win_id;
                        hold_cnt <= '0;
                        busy     <= 1'b1;
                        state    <= GRANT;
                    end else begin
                        gnt <= '0;
                    end
                end
                GRANT: begin
                    if (!req[gnt_id]) begin
                        // voluntary release wins over a coincident hold limit
                        gnt   <= '0;
                        ptr   <= rel_ptr;
                        state <= TURN;
                    end else if (hold_cnt == HOLD_LIM && !lock[gnt_id]) begin
                        gnt     <= '0;
                        timeout <= 1'b1;
                        ptr     <= rel_ptr;
                        state   <= TURN;
                    end else if (hold_cnt != HOLD_LIM) begin
                        hold_cnt <= hold_cnt + 8'd1;
                    end
                end
                TURN: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    gnt   <= '0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/cpu_bus_arbiter.md
Name: cpu_bus_arbiter

Overview:
- Round-robin arbiter that shares the CPU's single datapath/memory bus among N_REQ requesters (control FSM, DMA, debug port, etc.).
- Registered one-hot grant, one-cycle turnaround between owners, and a hold timeout so no requester can starve the others.
- Sits between the requesting masters and the bus mux select.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- MAX_HOLD, 8, maximum consecutive grant cycles before forced release (2..255).
- ID_W, 2, width of gnt_id; must equal ceil(log2(N_REQ)).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- req  input  N_REQ  per-requester bus request, level; held until done.
- lock  input  N_REQ  per-requester lock; suppresses timeout while the owner's bit is high.
- gnt  output  N_REQ  one-hot grant, registered.
- gnt_id  output  ID_W  binary index of the current owner; valid only while gnt != 0.
- busy  output  1  high when the FSM is not IDLE.
- timeout  output  1  one-cycle pulse when a grant is revoked by the hold limit.

Behaviour:
- Reset values, asynchronous on rst:
  - state=IDLE, gnt=0, gnt_id=0, busy=0, timeout=0.
  - ptr=0, hold_cnt=0.
  - Reset asserted mid-grant clears gnt in the same cycle, without waiting for a clock edge.
- FSM states: IDLE, GRANT, TURN.
- IDLE:
  - Search req starting at index ptr, then ptr+1 and upward, wrapping from N_REQ-1 to 0.
  - The first set bit wins: w.
  - If any bit of req is set: gnt<=onehot(w), gnt_id<=w, hold_cnt<=0, state<=GRANT.
  - Latency: req high before edge k gives gnt high after edge k (1 cycle).
  - If req=0: remain in IDLE, gnt=0.
- GRANT:
  - hold_cnt increments each cycle, saturating at MAX_HOLD-1.
  - Voluntary release: if req[gnt_id]=0, then gnt<=0, ptr<=(gnt_id+1) mod N_REQ, state<=TURN; timeout stays 0.
  - Forced release: if req[gnt_id]=1, hold_cnt==MAX_HOLD-1 and lock[gnt_id]=0, then gnt<=0, timeout<=1 for exactly one cycle, ptr<=(gnt_id+1) mod N_REQ, state<=TURN.
  - If req drop and the timeout condition occur in the same cycle, it is a voluntary release and no timeout pulse is issued.
  - With lock[gnt_id]=1 the grant holds indefinitely while req stays high.
  - Changes on other requesters' req bits are ignored during GRANT.
- TURN:
  - Exactly one cycle with gnt=0 (bus turnaround), then state<=IDLE.
  - req is not sampled during TURN.
  - The minimum gap between two grants is therefore 2 cycles: TURN plus the IDLE arbitration edge.
- busy=1 in GRANT and TURN, 0 in IDLE.
- Invariant: gnt is always zero or one-hot, never multi-hot.
- Pointer wrap: ptr = N_REQ-1 wraps to 0. Round-robin fairness guarantees every continuously-asserted request is granted within N_REQ grants.
- Single requester continuously high: granted, released by timeout, re-granted after 2 cycles. The pattern repeats with no lockup.

Optional Feature:
- Macro: ARB_PRIORITY_EN.
- Defined:
  - In IDLE, req[0] beats every other requester regardless of ptr.
  - ptr is not updated when requester 0 releases, so the rotation among 1..N_REQ-1 is preserved.
  - Requester 0 is still subject to the timeout and lock rules.
- Undefined: pure round-robin as described above; requester 0 gets no special treatment.

Test Plan (N_REQ=4, MAX_HOLD=8):
- Reset: assert rst mid-GRANT with gnt=4'b0100 → gnt=0, busy=0 and timeout=0 immediately; after release, req=4'b0001 is granted 1 cycle later with gnt_id=0.
- Round-robin: req=4'b1111 held, each owner drops req after 2 grant cycles → grant order 0,1,2,3,0, each grant separated by exactly 2 gnt=0 cycles.
- Timeout: req=4'b0010 held for 20 cycles, lock=0 → gnt=4'b0010 for 8 cycles, timeout pulses once, gnt=0 for 2 cycles, then re-grant; 2 timeout pulses total within 20 cycles.
- Lock: req[3]=1 and lock[3]=1 for 30 cycles → gnt=4'b1000 held all 30 cycles, timeout stays 0; after req[3] drops, gnt=0 next cycle and ptr=0.
- Simultaneous event: owner 2 drops req on the same cycle hold_cnt reaches 7 → release, timeout=0, next grant goes to requester 3 if req[3]=1.
- ARB_PRIORITY_EN: ptr=2, req=4'b0101 → requester 0 is granted; with the macro undefined → requester 2 is granted.
